// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling constants and baud divider math.
package uart_pkg;

  localparam int unsigned SMP_PER_BIT = 16;
  localparam int unsigned SMP_W       = 4;
  localparam int unsigned BIT_W       = 4;
  localparam int unsigned DATA_W      = 8;

  // Vote window sits around the bit centre (sample 8 of 0..15)
  localparam int unsigned SMP_VOTE0 = 7;
  localparam int unsigned SMP_VOTE1 = 8;
  localparam int unsigned SMP_VOTE2 = 9;

  localparam int unsigned LAST_DATA_BIT = 8;
  localparam int unsigned LAST_BIT      = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } rx_state_e;

  // Rounded clocks-per-sample divider; also used by transmit-side baud generators.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned ovs);
    return (clk_freq + baud * (ovs / 2)) / (baud * ovs);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: clock divider plus sample-in-bit and bit-in-frame counters.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned DIV = 163
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  output logic             tick_c,
  output logic [SMP_W-1:0] smp,
  output logic [BIT_W-1:0] bit_idx
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] div_cnt;

  assign tick_c = (div_cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      smp     <= '0;
      bit_idx <= '0;
    end else if (clr) begin
      div_cnt <= '0;
      smp     <= '0;
      bit_idx <= '0;
    end else if (tick_c) begin
      div_cnt <= '0;
      smp     <= smp + SMP_W'(1);
      // Bit counter steps on the sample wrap and stays within one frame
      if (smp == SMP_W'(SMP_PER_BIT - 1)) begin
        bit_idx <= (bit_idx == BIT_W'(LAST_BIT)) ? '0 : bit_idx + BIT_W'(1);
      end
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver with 16x oversampling, 3-sample majority vote and framing-error/break handling.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 25_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rs232_rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_int,
  output logic              frame_err
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);

  rx_state_e         state_q, state_d;
  logic              sync1, rx_s, rx_s_d;
  logic              fall_c;
  logic              clr_c;
  logic              tick_c;
  logic [SMP_W-1:0]  smp;
  logic [BIT_W-1:0]  bit_idx;
  logic              smp_a, smp_b;
  logic              vote_c, vote_en_c;
  logic [DATA_W-1:0] shreg, shreg_d;
  logic [DATA_W-1:0] rx_data_d;
  logic              rx_int_d, frame_err_d;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      sync1  <= rs232_rx;
      rx_s   <= sync1;
      rx_s_d <= rx_s;
    end
  end

  assign fall_c = rx_s_d & ~rx_s;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr_c),
    .tick_c  (tick_c),
    .smp     (smp),
    .bit_idx (bit_idx)
  );

  // First two vote samples; the third is the live rx_s on the vote tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_a <= 1'b1;
      smp_b <= 1'b1;
    end else if (tick_c) begin
      if (smp == SMP_W'(SMP_VOTE0)) smp_a <= rx_s;
      if (smp == SMP_W'(SMP_VOTE1)) smp_b <= rx_s;
    end
  end

  assign vote_en_c = tick_c && (smp == SMP_W'(SMP_VOTE2));
  assign vote_c    = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg     <= '0;
      rx_data   <= '0;
      rx_int    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg     <= shreg_d;
      rx_data   <= rx_data_d;
      rx_int    <= rx_int_d;
      frame_err <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg;
    rx_data_d   = rx_data;
    rx_int_d    = rx_int;
    frame_err_d = frame_err;
    clr_c       = 1'b0;

    case (state_q)
      IDLE: begin
        if (fall_c) begin
          clr_c   = 1'b1;
          state_d = START;
        end
      end

      START: begin
        if (vote_en_c) begin
          if (vote_c) begin
            state_d = IDLE;
          end else begin
            rx_int_d    = 1'b1;
            frame_err_d = 1'b0;
            state_d     = DATA;
          end
        end
      end

      DATA: begin
        if (vote_en_c) begin
          shreg_d = {vote_c, shreg[DATA_W-1:1]};
          if (bit_idx == BIT_W'(LAST_DATA_BIT)) state_d = STOP;
        end
      end

      // Leaving at mid-stop-bit lets the next start edge resynchronise early
      STOP: begin
        if (vote_en_c) begin
          rx_int_d = 1'b0;
          if (vote_c) begin
            rx_data_d   = shreg;
            frame_err_d = 1'b0;
            state_d     = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BRK;
          end
        end
      end

      BRK: begin
        if (rx_s) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Scoreboard bench for uart_rx_oversample: directed frames, glitch, break, baud skew and mid-frame reset.
module tb_uart_rx_oversample;

  // 2_457_600 / (16*9600) is exactly 16, so the divider is 16 clk per sample
  localparam int unsigned CLK_FREQ = 2_457_600;
  localparam int unsigned BAUD     = 9600;
  localparam int unsigned EXP_DIV  = 16;
  localparam int unsigned BIT_CLKS = 16 * EXP_DIV;
  localparam int unsigned EXP_RISE = 3 + 10 * EXP_DIV;
  localparam int unsigned EXP_FALL = 3 + 154 * EXP_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rs232_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_int;
  logic       frame_err;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    bit         timed;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;
  int          rise_cnt = 0;

  uart_rx_oversample #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs232_rx  (rs232_rx),
    .rx_data   (rx_data),
    .rx_int    (rx_int),
    .frame_err (frame_err)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Transmitter model: start, 8 data bits LSB first, stop; last stop cycle completes on the next negedge
  task automatic send_frame(input logic [7:0] b, input int unsigned bit_clks, input logic stop_val);
    logic [9:0] bits;
    bits = {stop_val, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rs232_rx = bits[i];
      if (i == 0) start_cyc = cyc;
      repeat (bit_clks - 1) @(negedge clk);
    end
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic ferr, input bit timed);
    exp_t e;
    e.data  = d;
    e.ferr  = ferr;
    e.timed = timed;
    exp_q.push_back(e);
  endtask

  // Monitor: checks every rx_int edge against the scoreboard head
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = rx_int;
      end else begin
        if (rx_int && !prev) begin
          rise_cnt++;
          check("frame_err cleared at start", 32'(frame_err), 32'd0);
          if (exp_q.size() > 0 && exp_q[0].timed)
            check("rx_int rise latency", cyc - start_cyc, EXP_RISE);
        end
        if (!rx_int && prev) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected rx_int fall: rx_data 0x%0h frame_err %0b", rx_data, frame_err);
          end else begin
            e = exp_q.pop_front();
            check("rx_data at rx_int fall", 32'(rx_data), 32'(e.data));
            check("frame_err at rx_int fall", 32'(frame_err), 32'(e.ferr));
            if (e.timed) check("rx_int fall latency", cyc - start_cyc, EXP_FALL);
          end
        end
        prev = rx_int;
      end
    end
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] cbits;
    int r0;

    rst_n    = 1'b0;
    rs232_rx = 1'b1;
    idle(5);
    check("reset rx_data", 32'(rx_data), 32'h00);
    check("reset rx_int", 32'(rx_int), 32'd0);
    check("reset frame_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    idle(BIT_CLKS);

    // Clean frame with latency checks
    expect_frame(8'hA5, 1'b0, 1'b1);
    send_frame(8'hA5, BIT_CLKS, 1'b1);
    idle(BIT_CLKS);

    // Back-to-back with minimum stop bit
    expect_frame(8'h00, 1'b0, 1'b0);
    send_frame(8'h00, BIT_CLKS, 1'b1);
    expect_frame(8'hFF, 1'b0, 1'b0);
    send_frame(8'hFF, BIT_CLKS, 1'b1);
    idle(BIT_CLKS);

    // 3/16-bit low glitch must be voted away
    r0 = rise_cnt;
    @(negedge clk);
    rs232_rx = 1'b0;
    idle(3 * EXP_DIV);
    rs232_rx = 1'b1;
    idle(2 * BIT_CLKS);
    check("glitch rx_int activity", 32'(rise_cnt), 32'(r0));
    check("glitch rx_data held", 32'(rx_data), 32'hFF);

    // Stop bit low, line held low afterwards (break)
    expect_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h3C, BIT_CLKS, 1'b0);
    r0 = rise_cnt;
    idle(3 * BIT_CLKS);
    check("break no retrigger", 32'(rise_cnt), 32'(r0));
    check("break frame_err held", 32'(frame_err), 32'd1);
    check("break rx_data held", 32'(rx_data), 32'hFF);
    rs232_rx = 1'b1;
    idle(BIT_CLKS);

    expect_frame(8'h55, 1'b0, 1'b1);
    send_frame(8'h55, BIT_CLKS, 1'b1);
    idle(BIT_CLKS);

    // Transmitter +/-2% baud skew
    expect_frame(8'h81, 1'b0, 1'b0);
    send_frame(8'h81, 261, 1'b1);
    idle(BIT_CLKS);
    expect_frame(8'h81, 1'b0, 1'b0);
    send_frame(8'h81, 251, 1'b1);
    idle(BIT_CLKS);

    // Reset in the middle of data bit 4 of 8'hC3
    cbits = {1'b1, 8'hC3, 1'b0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rs232_rx = cbits[i];
      repeat (((i == 5) ? BIT_CLKS / 2 : BIT_CLKS) - 1) @(negedge clk);
    end
    check("rx_int high before reset", 32'(rx_int), 32'd1);
    rst_n    = 1'b0;
    rs232_rx = 1'b1;
    idle(4);
    check("mid-frame reset rx_data", 32'(rx_data), 32'h00);
    check("mid-frame reset rx_int", 32'(rx_int), 32'd0);
    check("mid-frame reset frame_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    idle(2 * BIT_CLKS);

    expect_frame(8'h12, 1'b0, 1'b1);
    send_frame(8'h12, BIT_CLKS, 1'b1);

    for (int i = 0; i < 4 * BIT_CLKS && exp_q.size() > 0; i++) @(negedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    check("final rx_data", 32'(rx_data), 32'h12);
    check("final frame_err", 32'(frame_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
